// File: rtl/lif_layer_q14.sv
// Leaky integrate-and-fire layer in Q14: accumulates F x N weighted presynaptic
// current one weight per cycle, then updates one neuron membrane per cycle.
module lif_layer_q14 #(
  parameter int F  = 48,
  parameter int N  = 96,
  parameter int Q  = 14,
  parameter int RW = 8,
  localparam int AW = (F * N > 1) ? $clog2(F * N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic [F-1:0]       pre_bits,
  input  logic signed [15:0] lambda_v,
  input  logic signed [31:0] v_th,
  input  logic signed [31:0] v_reset,
  input  logic [RW-1:0]      refrac_len,
  output logic               w_re,
  output logic [AW-1:0]      w_raddr,
  input  logic signed [15:0] w_rdata,
  output logic               busy,
  output logic [N-1:0]       post_bits,
  output logic               post_valid
);
  localparam int FW = (F > 1) ? $clog2(F) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  // Handshake: step is a request honoured only in S_IDLE; w_rdata is consumed
  // exactly one cycle after w_re; post_valid is a one-cycle completion pulse.
  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_MEM, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      k_q, k_d;
  logic [FW-1:0]      f_q, f_d, rd_f_q, rd_f_d;
  logic [NW-1:0]      n_q, n_d, rd_n_q, rd_n_d;
  logic               rd_vld_q, rd_vld_d;
  logic [F-1:0]       pre_q, pre_d;
  logic signed [31:0] acc_q [N];
  logic signed [31:0] acc_d [N];
  logic signed [31:0] v_q [N];
  logic signed [31:0] v_d [N];
  logic [RW-1:0]      refr_q [N];
  logic [RW-1:0]      refr_d [N];
  logic [N-1:0]       shadow_q, shadow_d;
  logic [N-1:0]       post_bits_q, post_bits_d;

  logic signed [47:0] lam_x, v_x, acc_x, prod, rnd, vsum;
  logic signed [31:0] v_new;
  logic               fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      f_q         <= '0;
      n_q         <= '0;
      rd_f_q      <= '0;
      rd_n_q      <= '0;
      rd_vld_q    <= 1'b0;
      pre_q       <= '0;
      shadow_q    <= '0;
      post_bits_q <= '0;
      for (int i = 0; i < N; i++) begin
        acc_q[i]  <= '0;
        v_q[i]    <= '0;
        refr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      f_q         <= f_d;
      n_q         <= n_d;
      rd_f_q      <= rd_f_d;
      rd_n_q      <= rd_n_d;
      rd_vld_q    <= rd_vld_d;
      pre_q       <= pre_d;
      shadow_q    <= shadow_d;
      post_bits_q <= post_bits_d;
      acc_q       <= acc_d;
      v_q         <= v_d;
      refr_q      <= refr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (step) state_d = S_ACC;
      S_ACC:   if (k_q == AW'(F * N - 1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_MEM;
      S_MEM:   if (n_q == NW'(N - 1)) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Membrane update for the neuron currently addressed by n_q (48-bit datapath).
  always_comb begin
    lam_x = {{32{lambda_v[15]}}, lambda_v};
    v_x   = {{16{v_q[n_q][31]}}, v_q[n_q]};
    acc_x = {{16{acc_q[n_q][31]}}, acc_q[n_q]};
    prod  = lam_x * v_x;
    rnd   = prod + (prod[47] ? -(48'sd1 <<< (Q - 1)) : (48'sd1 <<< (Q - 1)));
    vsum  = (rnd >>> Q) + acc_x;
    if (vsum > 48'sd2147483647)       v_new = 32'sh7fffffff;
    else if (vsum < -48'sd2147483648) v_new = 32'sh80000000;
    else                              v_new = vsum[31:0];
    fire = (refr_q[n_q] == '0) && (v_new >= v_th);
  end

  always_comb begin
    k_d         = k_q;
    f_d         = f_q;
    n_d         = n_q;
    pre_d       = pre_q;
    acc_d       = acc_q;
    v_d         = v_q;
    refr_d      = refr_q;
    shadow_d    = shadow_q;
    post_bits_d = post_bits_q;
    rd_vld_d    = (state_q == S_ACC);
    rd_f_d      = f_q;
    rd_n_d      = n_q;
    case (state_q)
      S_IDLE: begin
        if (step) begin
          pre_d = pre_bits;
          k_d   = '0;
          f_d   = '0;
          n_d   = '0;
          for (int i = 0; i < N; i++) acc_d[i] = '0;
        end
      end
      S_ACC: begin
        k_d = k_q + AW'(1);
        if (n_q == NW'(N - 1)) begin
          n_d = '0;
          f_d = f_q + FW'(1);
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      S_DRAIN: n_d = '0;
      S_MEM: begin
        if (refr_q[n_q] != '0) begin
          v_d[n_q]    = v_reset;
          refr_d[n_q] = refr_q[n_q] - RW'(1);
        end else if (fire) begin
          v_d[n_q]    = v_reset;
          refr_d[n_q] = refrac_len;
        end else begin
          v_d[n_q] = v_new;
        end
        shadow_d[n_q] = fire;
        if (n_q == NW'(N - 1)) begin
          n_d         = '0;
          post_bits_d = shadow_d;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      default: ;
    endcase
    // Read data lands one cycle after its address; this also covers S_DRAIN.
    if (rd_vld_q && pre_q[rd_f_q])
      acc_d[rd_n_q] = acc_q[rd_n_q] + {{16{w_rdata[15]}}, w_rdata};
  end

  always_comb begin
    w_re       = 1'b0;
    w_raddr    = '0;
    busy       = (state_q != S_IDLE);
    post_valid = 1'b0;
    case (state_q)
      S_ACC: begin
        w_re    = 1'b1;
        w_raddr = k_q;
      end
      S_OUT:   post_valid = 1'b1;
      default: ;
    endcase
  end

  assign post_bits = post_bits_q;

endmodule

// File: tb/tb_lif_layer_q14.sv
// Randomized and directed bench for lif_layer_q14 against a per-timestep
// behavioural model of the layer (small F/N instance).
module tb_lif_layer_q14;
  localparam int F  = 3;
  localparam int N  = 4;
  localparam int RW = 4;
  localparam int AW = $clog2(F * N);
  localparam longint VMAX = 64'sd2147483647;
  localparam longint VMIN = -64'sd2147483648;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               step = 1'b0;
  logic [F-1:0]       pre_bits = '0;
  logic signed [15:0] lambda_v = 16'sd16384;
  logic signed [31:0] v_th = 32'sd20000;
  logic signed [31:0] v_reset = '0;
  logic [RW-1:0]      refrac_len = '0;
  logic               w_re;
  logic [AW-1:0]      w_raddr;
  logic signed [15:0] w_rdata = '0;
  logic               busy;
  logic [N-1:0]       post_bits;
  logic               post_valid;

  lif_layer_q14 #(.F(F), .N(N), .Q(14), .RW(RW)) dut (
    .clk(clk), .rst(rst), .step(step), .pre_bits(pre_bits),
    .lambda_v(lambda_v), .v_th(v_th), .v_reset(v_reset), .refrac_len(refrac_len),
    .w_re(w_re), .w_raddr(w_raddr), .w_rdata(w_rdata), .busy(busy),
    .post_bits(post_bits), .post_valid(post_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  // weight memory, one-cycle read latency; garbage when not reading
  logic signed [15:0] wmem [F*N];
  always @(posedge clk) w_rdata <= w_re ? wmem[w_raddr] : 16'($urandom);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural model
  longint mv [N];
  int     mrefr [N];
  logic [N-1:0] exp_q[$];

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      mv[n] = 0;
      mrefr[n] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input logic [F-1:0] pre);
    logic [N-1:0] spk;
    longint acc, p, r, s;
    spk = '0;
    for (int n = 0; n < N; n++) begin
      acc = 0;
      for (int f = 0; f < F; f++)
        if (pre[f]) acc += longint'(wmem[f*N+n]);
      if (mrefr[n] != 0) begin
        mv[n] = longint'(v_reset);
        mrefr[n] = mrefr[n] - 1;
      end else begin
        p = longint'(lambda_v) * mv[n];
        r = (p >= 0) ? ((p + 8192) >>> 14) : ((p - 8192) >>> 14);
        s = r + acc;
        if (s > VMAX) s = VMAX;
        if (s < VMIN) s = VMIN;
        if (s >= longint'(v_th)) begin
          spk[n] = 1'b1;
          mv[n] = longint'(v_reset);
          mrefr[n] = int'(refrac_len);
        end else begin
          mv[n] = s;
        end
      end
    end
    exp_q.push_back(spk);
  endtask

  // scoreboard: post_bits on every post_valid, held otherwise
  logic [N-1:0] last_pb = '0;
  always @(negedge clk) begin
    if (rst) begin
      last_pb = '0;
    end else if (post_valid) begin
      if (exp_q.size() == 0) check_eq("unexpected_post_valid", 32'd1, 32'd0);
      else check_eq("post_bits", 32'(post_bits), 32'(exp_q.pop_front()));
      last_pb = post_bits;
    end else begin
      check_eq("post_bits_hold", 32'(post_bits), 32'(last_pb));
    end
  end

  // read address sequence: 0..F*N-1 per timestep, no repeats or gaps
  int exp_addr = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 0;
    end else begin
      if (w_re) begin
        check_eq("w_raddr", 32'(w_raddr), 32'(exp_addr));
        exp_addr++;
      end
      if (post_valid) begin
        check_eq("rd_count", 32'(exp_addr), 32'(F * N));
        exp_addr = 0;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic clear_w();
    for (int i = 0; i < F * N; i++) wmem[i] = '0;
  endtask

  task automatic do_step(input logic [F-1:0] pre, input bit poke);
    int c, nb;
    model_step(pre);
    @(negedge clk); step = 1'b1; pre_bits = pre;
    @(negedge clk); step = 1'b0; pre_bits = F'($urandom);
    c = 0; nb = 0;
    while (!post_valid && c < 200) begin
      if (busy) nb++;
      step = poke && (c == 5);
      @(negedge clk); c++;
    end
    check_eq("pv_latency", 32'(c), 32'(F * N + N + 1));
    if (busy) nb++;
    check_eq("busy_len", 32'(nb), 32'(F * N + N + 2));
    step = poke;
    @(negedge clk); step = 1'b0;
    check_eq("idle_after", {30'd0, busy, post_valid}, 32'd0);
  endtask

  initial begin
    int c;
    logic [F-1:0] pre;
    clear_w();
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 32'({w_re, w_raddr, busy, post_bits, post_valid}), 32'd0);
    rst = 1'b0;

    // two-neuron scenario: neuron 1 fires, neuron 0 integrates
    wmem[0] = 16'sd8000; wmem[N+1] = 16'sd30000;
    do_step(3'b011, 1'b0);
    check_eq("tp1_bits", 32'(post_bits), 32'h2);

    // integrate to threshold over three steps
    do_reset();
    do_step(3'b001, 1'b0); check_eq("int_s1", 32'(post_bits), 32'h0);
    do_step(3'b001, 1'b1); check_eq("int_s2", 32'(post_bits), 32'h0);
    do_step(3'b001, 1'b0); check_eq("int_s3", 32'(post_bits), 32'h1);
    do_step(3'b000, 1'b0); check_eq("int_after_reset_v", 32'(post_bits), 32'h0);

    // rounding of +3 * 0.5 and -3 * 0.5
    do_reset(); clear_w(); wmem[0] = 16'sd3; v_th = 32'sd100000;
    do_step(3'b001, 1'b0);
    lambda_v = 16'sd8192; do_step(3'b000, 1'b0);
    lambda_v = 16'sd16384; v_th = 32'sd2; do_step(3'b000, 1'b0);
    check_eq("round_pos", 32'(post_bits), 32'h1);
    do_reset(); wmem[0] = -16'sd3; v_th = 32'sd100000;
    do_step(3'b001, 1'b0);
    lambda_v = 16'sd8192; do_step(3'b000, 1'b0);
    lambda_v = 16'sd16384; v_th = -32'sd1; do_step(3'b000, 1'b0);
    check_eq("round_neg", 32'(post_bits), 32'he);

    // refractory period of two steps
    do_reset(); clear_w(); wmem[N+1] = 16'sd30000; v_th = 32'sd20000; refrac_len = 4'd2;
    do_step(3'b010, 1'b0); check_eq("refr_s1", 32'(post_bits[1]), 32'd1);
    do_step(3'b010, 1'b0); check_eq("refr_s2", 32'(post_bits[1]), 32'd0);
    do_step(3'b010, 1'b0); check_eq("refr_s3", 32'(post_bits[1]), 32'd0);
    do_step(3'b010, 1'b0); check_eq("refr_s4", 32'(post_bits[1]), 32'd1);

    // step held high: restart only in the cycle after post_valid
    do_reset(); refrac_len = '0; wmem[0] = 16'sd12000;
    model_step(3'b001); model_step(3'b001);
    @(negedge clk); step = 1'b1; pre_bits = 3'b001;
    c = 0; while (!post_valid && c < 200) begin @(negedge clk); c++; end
    check_eq("held_pv1", 32'(post_valid), 32'd1);
    @(negedge clk); check_eq("held_gap", 32'(busy), 32'd0);
    @(negedge clk); check_eq("held_restart", 32'(busy), 32'd1); step = 1'b0;
    c = 0; while (!post_valid && c < 200) begin @(negedge clk); c++; end
    check_eq("held_pv2", 32'(post_valid), 32'd1);
    @(negedge clk); @(negedge clk); check_eq("held_stop", 32'(busy), 32'd0);

    // asynchronous reset in the middle of accumulation
    do_step(3'b001, 1'b0);
    @(negedge clk); step = 1'b1; pre_bits = 3'b111;
    @(negedge clk); step = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_eq("rst_async", 32'({w_re, w_raddr, busy, post_bits, post_valid}), 32'd0);
    model_reset();
    @(negedge clk); @(negedge clk); rst = 1'b0;
    do_step(3'b001, 1'b0);
    check_eq("post_rst_fresh", 32'(post_bits), 32'h0);

    // saturation with lambda = -2.0 and threshold at the positive limit
    do_reset(); clear_w(); wmem[0] = 16'sd30000;
    lambda_v = -16'sd32768; v_th = 32'sh7fffffff; v_reset = -32'sd5;
    for (int i = 0; i < 20; i++) do_step(3'b001, 1'b0);

    // randomized timesteps
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < F * N; i++) wmem[i] = 16'(int'($urandom_range(0, 16000)) - 4000);
      lambda_v   = ($urandom_range(0, 4) == 0) ? -16'sd8192 : 16'($urandom_range(8192, 16384));
      v_th       = int'($urandom_range(0, 40000)) - 5000;
      v_reset    = int'($urandom_range(0, 4000)) - 2000;
      refrac_len = RW'($urandom_range(0, 3));
      for (int j = 0; j < 6; j++) begin
        pre = F'($urandom);
        do_step(pre, 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
